// File: rtl/sample_loader_pkg.sv
// Shared definitions for the autoencoder sample loader.
// Holds state encodings, word width and sector/address widths.
// No logic; imported by sample_loader and loader_addr_counter.
package sample_loader_pkg;

  localparam int WORD_W = 16;  // fixed-point data word
  localparam int SECT_W = 4;   // sector select width
  localparam int ADDR_W = 4;   // address within a sector
  localparam int CYC_W  = 16;  // run-phase cycle counter

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// Wrapping address counter for the loader's target sector.
// Latency: count updates one clock after inc/clear; last is combinational.
// Backpressure: none; the caller only pulses inc on an accepted word.
// Ports: clock/reset (sync, active-high), clear, inc, count, last (count == LAST).
module loader_addr_counter
  import sample_loader_pkg::*;
#(
  parameter int LAST = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  assign last = (count == ADDR_W'(LAST));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sample_loader.sv
// Host ingress stage: loads one sample into a memory sector, starts the core, reports completion.
// Latency: accepted word written 1 cycle later; core_start 2 cycles after last accept; DONE >= 4 cycles after.
// Backpressure: in_ready drops from START through DONE; the host holds its word until IDLE.
// Ports: clock, reset (sync, active-high); in_data/in_valid/in_ready host handshake;
//   mem_wr_data/sector/addr/en + mem_sel to the shared write port; core_start/core_run/core_done
//   to the core; sample_done pulse, sample_count, sticky error.
// Optional feature: define LOADER_TIMEOUT_EN to abort RUN after RUN_CYCLES cycles and flag error.
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int WORDS_PER_SAMPLE = 16,
  parameter int TARGET_SECTOR    = 0,
  parameter int RUN_CYCLES       = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] mem_wr_data,
  output logic [SECT_W-1:0] mem_wr_sector,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_wr_en,
  output logic              mem_sel,
  output logic              core_start,
  output logic              core_run,
  input  logic              core_done,
  output logic              sample_done,
  output logic [15:0]       sample_count,
  output logic              error
);

  state_t              state;
  logic                hs;
  logic [ADDR_W-1:0]   addr;
  logic                addr_last;
  logic                done_ok;
  logic                timeout;

  // in_ready is gated by reset so no word is taken in the reset cycle.
  assign in_ready      = !reset && (state == ST_IDLE || state == ST_LOAD);
  assign hs            = in_valid && in_ready;
  assign mem_wr_sector = SECT_W'(TARGET_SECTOR);

  // core_start is high exactly in the first RUN cycle, so it masks a
  // core_done left over from the previous program.
  assign done_ok = core_done && !core_start;

  loader_addr_counter #(
    .LAST (WORDS_PER_SAMPLE - 1)
  ) u_addr (
    .clock (clock),
    .reset (reset),
    .clear (state == ST_DONE),
    .inc   (hs),
    .count (addr),
    .last  (addr_last)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [CYC_W-1:0] cyc_cnt;

  // cyc_cnt holds k-1 in the k-th RUN cycle, so RUN lasts RUN_CYCLES cycles.
  assign timeout = (cyc_cnt == CYC_W'(RUN_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= '0;
      error   <= 1'b0;
    end else begin
      if (state == ST_START) begin
        cyc_cnt <= '0;
      end else if (state == ST_RUN) begin
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      end
      // A valid core_done in the same cycle beats the timeout.
      if (state == ST_RUN && timeout && !done_ok) begin
        error <= 1'b1;
      end
    end
  end
`else
  // RUN_CYCLES is always positive, so this is a constant 0: RUN waits forever.
  assign timeout = (RUN_CYCLES < 0);
  assign error   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      mem_wr_data  <= '0;
      mem_wr_addr  <= '0;
      mem_wr_en    <= 1'b0;
      mem_sel      <= 1'b1;
      core_start   <= 1'b0;
      core_run     <= 1'b0;
      sample_done  <= 1'b0;
      sample_count <= '0;
    end else begin
      mem_wr_en   <= hs;
      core_start  <= 1'b0;
      sample_done <= 1'b0;
      if (hs) begin
        mem_wr_data <= in_data;
        mem_wr_addr <= addr;
      end
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (hs) state <= addr_last ? ST_START : ST_LOAD;
        end
        ST_START: begin
          // Last write is on the port this cycle; hand the port to the core next.
          state      <= ST_RUN;
          core_start <= 1'b1;
          core_run   <= 1'b1;
          mem_sel    <= 1'b0;
        end
        ST_RUN: begin
          if (done_ok || timeout) begin
            state        <= ST_DONE;
            core_run     <= 1'b0;
            mem_sel      <= 1'b1;
            sample_done  <= 1'b1;
            sample_count <= sample_count + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
